// File: rtl/ov7670_sccb_cfg.sv
// OV7670 configuration sequencer: after a power-up delay, walks the register LUT
// and issues one 3-phase SCCB write (ID, register, data) per entry on SIOC/SIOD.
module ov7670_sccb_cfg #(
  parameter int unsigned CLK_FREQ_HZ    = 25_000_000,
  parameter int unsigned SCCB_FREQ_HZ   = 100_000,
  parameter logic [7:0]  DEV_ADDR       = 8'h42,
  parameter int unsigned START_INDEX    = 2,
  parameter int unsigned LAST_INDEX     = 166,
  parameter int unsigned STARTUP_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  lut_index,
  input  logic [15:0] lut_data,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe,
  input  logic        siod_in,
  output logic        busy,
  output logic        done,
  output logic        nack_seen
);

  localparam int unsigned QTR_RAW  = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int unsigned QTR      = (QTR_RAW < 1) ? 1 : QTR_RAW;
  localparam int unsigned QW       = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int unsigned PWR_LAST = (STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0;
  localparam int unsigned PW       = (PWR_LAST > 0) ? $clog2(PWR_LAST + 1) : 1;

  localparam logic [2:0] S_WAIT_PWR = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_START    = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;
  localparam logic [2:0] S_NEXT     = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]    state;
  logic [PW-1:0] pwr_cnt;
  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [4:0]    bitcnt;
  logic [26:0]   shreg;
  logic          timed;
  logic          tick;
  logic          dc_bit;

  assign timed  = (state == S_START) || (state == S_SEND) ||
                  (state == S_STOP)  || (state == S_GAP);
  assign tick   = timed && (qcnt == QW'(QTR - 1));
  // The 9th slot of each phase is released so the camera may drive it.
  assign dc_bit = (bitcnt == 5'd18) || (bitcnt == 5'd9) || (bitcnt == 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT_PWR;
      pwr_cnt   <= '0;
      qcnt      <= '0;
      quarter   <= '0;
      bitcnt    <= '0;
      shreg     <= '1;
      lut_index <= 8'(START_INDEX);
      nack_seen <= 1'b0;
    end else begin
      qcnt <= (tick || !timed) ? '0 : qcnt + 1'b1;
      case (state)
        S_WAIT_PWR: begin
          if (pwr_cnt == PW'(PWR_LAST)) state <= S_LOAD;
          else pwr_cnt <= pwr_cnt + 1'b1;
        end
        S_LOAD: begin
          shreg   <= {DEV_ADDR, 1'b1, lut_data[15:8], 1'b1, lut_data[7:0], 1'b1};
          quarter <= '0;
          state   <= S_START;
        end
        S_START: begin
          if (tick) begin
            if (quarter == 2'd1) begin
              quarter <= '0;
              bitcnt  <= 5'd26;
              state   <= S_SEND;
            end else begin
              quarter <= quarter + 1'b1;
            end
          end
        end
        S_SEND: begin
          if (tick) begin
            quarter <= quarter + 1'b1;
            if (quarter == 2'd2 && dc_bit && siod_in) nack_seen <= 1'b1;
            if (quarter == 2'd3) begin
              if (bitcnt == 5'd0) begin
                state <= S_STOP;
              end else begin
                bitcnt <= bitcnt - 1'b1;
                shreg  <= {shreg[25:0], 1'b1};
              end
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (quarter == 2'd2) begin
              quarter <= '0;
              state   <= S_GAP;
            end else begin
              quarter <= quarter + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            quarter <= quarter + 1'b1;
            if (quarter == 2'd3) state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (lut_index == 8'(LAST_INDEX)) begin
            state <= S_DONE;
          end else begin
            lut_index <= lut_index + 1'b1;
            state     <= S_LOAD;
          end
        end
        S_DONE: begin
          if (start) begin
            lut_index <= 8'(START_INDEX);
            nack_seen <= 1'b0;
            state     <= S_LOAD;
          end
        end
        default: state <= S_WAIT_PWR;
      endcase
    end
  end

  always_comb begin
    sioc     = 1'b1;
    siod_out = 1'b1;
    siod_oe  = 1'b0;
    case (state)
      S_START: begin
        siod_oe  = 1'b1;
        siod_out = (quarter == 2'd0);
      end
      S_SEND: begin
        sioc     = quarter[1];
        siod_oe  = !dc_bit;
        siod_out = dc_bit | shreg[26];
      end
      S_STOP: begin
        sioc     = (quarter != 2'd0);
        siod_oe  = 1'b1;
        siod_out = (quarter == 2'd2);
      end
      default: ;
    endcase
  end

  assign busy = (state != S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_ov7670_sccb_cfg.sv
// Bench for ov7670_sccb_cfg: a pin-level SCCB monitor decodes writes and compares
// them, plus cycle-exact sequence timing, against expectations derived from the LUT.
module tb_ov7670_sccb_cfg;

  localparam int unsigned START_IDX = 2;
  localparam int unsigned LAST_IDX  = 4;
  localparam int unsigned ENTRY     = 119;
  localparam int unsigned FIRST_LD  = 10;
  localparam logic [26:0] REL_MASK  = 27'h7FF_FFFF ^ 27'h004_0201;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic        sioc;
  logic        siod_out;
  logic        siod_oe;
  logic        siod_in;
  logic        busy;
  logic        done;
  logic        nack_seen;
  logic        nack_drv;

  logic [15:0] lut_mem [256];
  int unsigned cyc;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [26:0] mon_frames [$];
  logic [26:0] mon_masks  [$];
  int          mon_lens   [$];

  ov7670_sccb_cfg #(
    .CLK_FREQ_HZ   (400),
    .SCCB_FREQ_HZ  (100),
    .DEV_ADDR      (8'h42),
    .START_INDEX   (START_IDX),
    .LAST_INDEX    (LAST_IDX),
    .STARTUP_CYCLES(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .lut_index(lut_index),
    .lut_data (lut_data),
    .sioc     (sioc),
    .siod_out (siod_out),
    .siod_oe  (siod_oe),
    .siod_in  (siod_in),
    .busy     (busy),
    .done     (done),
    .nack_seen(nack_seen)
  );

  always #5 clk = ~clk;

  assign lut_data = lut_mem[lut_index];
  // Camera model: acks (holds low) whenever the master releases the line, unless forced.
  assign siod_in  = siod_oe ? siod_out : nack_drv;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin : monitor
    logic p_scl, p_sda, sda, in_frame;
    logic [27:0] fb, fm;
    int nb;
    p_scl = 1'b1; p_sda = 1'b1; in_frame = 1'b0; fb = '0; fm = '0; nb = 0;
    forever begin
      @(negedge clk);
      sda = siod_oe ? siod_out : 1'b1;
      if (rst) begin
        in_frame = 1'b0;
      end else if (sioc && p_scl && p_sda && !sda) begin
        in_frame = 1'b1; nb = 0; fb = '0; fm = '0;
      end else if (sioc && p_scl && !p_sda && sda && in_frame) begin
        // The SIOC rise that precedes the stop edge is not a data bit.
        mon_frames.push_back(fb[27:1]);
        mon_masks.push_back(fm[27:1]);
        mon_lens.push_back(nb - 1);
        in_frame = 1'b0;
      end else if (sioc && !p_scl && in_frame) begin
        fb = {fb[26:0], sda};
        fm = {fm[26:0], siod_oe};
        nb++;
      end
      p_scl = sioc;
      p_sda = sda;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_start(output int unsigned s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic randomize_lut();
    for (int unsigned i = START_IDX; i <= LAST_IDX; i++)
      lut_mem[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {sioc, siod_out, siod_oe, busy, done, nack_seen, lut_index},
          {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(START_IDX)});
  endtask

  // Called on the negedge where rst is released (cycle 0).
  task automatic powerup_check();
    for (int unsigned n = 0; n <= 12; n++) begin
      if (n > 0) @(negedge clk);
      if (n <= 10)      check_reset_vals("pwr_hold");
      else if (n == 11) check("start_q0", {sioc, siod_oe, siod_out}, 3'b111);
      else              check("start_fall", {sioc, siod_oe, siod_out, lut_index},
                              {3'b110, 8'(START_IDX)});
    end
  endtask

  task automatic check_frames();
    logic [26:0] f, m;
    int l;
    check("n_frames", mon_frames.size(), LAST_IDX - START_IDX + 1);
    for (int unsigned i = START_IDX; i <= LAST_IDX; i++) begin
      if (mon_frames.size() == 0) break;
      f = mon_frames.pop_front();
      m = mon_masks.pop_front();
      l = mon_lens.pop_front();
      check("frame_len", l, 27);
      check("byte_id", f[26:19], 8'h42);
      check("byte_reg", f[17:10], lut_mem[i][15:8]);
      check("byte_dat", f[8:1], lut_mem[i][7:0]);
      check("dc_release", m, REL_MASK);
    end
  endtask

  task automatic clear_mon();
    mon_frames.delete();
    mon_masks.delete();
    mon_lens.delete();
  endtask

  task automatic idle_hold();
    int unsigned k;
    k = $urandom_range(3, 15);
    for (int unsigned i = 0; i < k; i++) begin
      @(negedge clk);
      check("idle_lines", {sioc, siod_oe, done, busy}, 4'b1010);
    end
  endtask

  initial begin
    int unsigned s, l1;
    rst = 1'b1; start = 1'b0; nack_drv = 1'b0;
    for (int unsigned i = 0; i < 256; i++) lut_mem[i] = 16'($urandom);
    lut_mem[2] = 16'h3a04;
    lut_mem[3] = 16'h0000;
    lut_mem[4] = 16'($urandom);

    // Run A: power-up, fixed entries, NACK on index 3, ignored start while busy
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    rst = 1'b0;
    powerup_check();
    wait_cyc(FIRST_LD + ENTRY - 1);
    check("idx_hold", lut_index, 2);
    wait_cyc(FIRST_LD + ENTRY);
    check("idx_next", lut_index, 3);
    l1 = FIRST_LD + ENTRY;
    wait_cyc(l1 + 73);
    check("nack_before", nack_seen, 0);
    nack_drv = 1'b1;
    @(negedge clk);
    nack_drv = 1'b0;
    check("nack_set", nack_seen, 1);
    wait_cyc(250);
    pulse_start(s);
    check("busy_start_ign", {busy, nack_seen, lut_index}, {2'b11, 8'd4});
    wait_cyc(FIRST_LD + 3 * ENTRY - 1);
    check("pre_done", {busy, done}, 2'b10);
    wait_cyc(FIRST_LD + 3 * ENTRY);
    check("done_a", {busy, done, nack_seen, lut_index}, {3'b011, 8'd4});
    check_frames();
    idle_hold();
    check("nack_sticky", nack_seen, 1);

    // Run B: restart from DONE with random entries
    clear_mon();
    randomize_lut();
    pulse_start(s);
    check("restart_load", {nack_seen, busy, lut_index}, {2'b01, 8'(START_IDX)});
    @(negedge clk);
    check("restart_q0", {sioc, siod_oe, siod_out}, 3'b111);
    @(negedge clk);
    check("restart_fall", {sioc, siod_oe, siod_out}, 3'b110);
    wait_cyc(s + 3 * ENTRY - 1);
    check("pre_done_b", {busy, done}, 2'b10);
    wait_cyc(s + 3 * ENTRY);
    check("done_b", {busy, done, nack_seen}, 3'b010);
    check_frames();
    idle_hold();

    // Run C: reset asserted during SEND bit 15 of index 3, then full rerun
    clear_mon();
    randomize_lut();
    pulse_start(s);
    l1 = s + ENTRY;
    wait_cyc(l1 + 48);
    check("pre_rst_send", {sioc, siod_oe, busy, lut_index}, {3'b011, 8'd3});
    rst = 1'b1;
    #1;
    check_reset_vals("rst_immediate");
    repeat (3) @(negedge clk);
    clear_mon();
    rst = 1'b0;
    powerup_check();
    wait_cyc(FIRST_LD + 3 * ENTRY - 1);
    check("pre_done_c", {busy, done}, 2'b10);
    wait_cyc(FIRST_LD + 3 * ENTRY);
    check("done_c", {busy, done, nack_seen}, 3'b010);
    check_frames();
    idle_hold();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no completion expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ov7670_sccb_cfg.md
# ov7670_sccb_cfg

Configuration sequencer and SCCB write engine for the OV7670 camera. After reset and a power-up delay, it walks the register-configuration LUT one index at a time and latches each 16-bit `{reg_addr, reg_data}` word. It then issues a 3-phase SCCB write (device ID, register, data) on SIOC/SIOD. It sits directly downstream of the config LUT and drives the camera's SCCB pins through top-level tristate buffers.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 25_000_000: frequency of `clk`.
- `SCCB_FREQ_HZ`, 100_000: SIOC bit rate.
- `DEV_ADDR`, 8'h42: SCCB write ID.
- `START_INDEX`, 2: first LUT index written. Indices 0–1 are ID-read entries and are never written.
- `LAST_INDEX`, 166: last LUT index written.
- `STARTUP_CYCLES`, 1_000_000: `clk` cycles to wait after reset before the first write.

Ports:
- `clk`, in, 1: sole clock; all state on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that re-runs the full sequence from `START_INDEX`. Honoured only in DONE.
- `lut_index`, out, 8: index presented to the LUT.
- `lut_data`, in, 16: `{reg_addr[15:8], reg_data[7:0]}`. Combinational, valid the cycle after `lut_index` changes.
- `sioc`, out, 1: SCCB clock, driven push-pull.
- `siod_out`, out, 1: SIOD drive value.
- `siod_oe`, out, 1: 1 = drive `siod_out`, 0 = release (pull-up).
- `siod_in`, in, 1: SIOD pad readback.
- `busy`, out, 1: high from reset release until DONE.
- `done`, out, 1: high while in DONE.
- `nack_seen`, out, 1: sticky flag; set if any don't-care bit samples 1. Cleared by `rst` or an accepted `start`.

## Operation
- Quarter-bit tick: `QTR = CLK_FREQ_HZ / (4*SCCB_FREQ_HZ)` (integer floor, ≥1). A counter pulses `tick` every `QTR` cycles, and only in START/SEND/STOP/GAP.
- Every LUT entry in `[START_INDEX, LAST_INDEX]` is written, including entries that read as 16'h0000 (0x00 GAIN ← 0x00 is a legal write). There is no skipping and no filtering.
- States:
  - WAIT_PWR: count `STARTUP_CYCLES`, then go to LOAD.
  - LOAD: 1 cycle. Latch `shreg = {DEV_ADDR, 1'b1, lut_data[15:8], 1'b1, lut_data[7:0], 1'b1}` (27 bits, MSB first; each `1` is a don't-care slot). Go to START.
  - START: 2 quarters. q0: `sioc=1`, SIOD driven 1. q1: SIOD driven 0.
  - SEND: 27 bits × 4 quarters, with the bit counter running 26→0.
    - q0: `sioc=0` and the new bit is applied. For data bits, `siod_oe=1` and `siod_out=bit`. For don't-care bits (counter 18, 9, 0), `siod_oe=0`.
    - q1: `sioc=0`.
    - q2 and q3: `sioc=1`.
    - On a don't-care bit, `siod_in` is sampled at the q2→q3 tick; a 1 sets `nack_seen`. Transmission continues regardless; there is no retry.
  - STOP: 3 quarters. (`sioc=0`, drive 0), then (`sioc=1`, drive 0), then (`sioc=1`, drive 1).
  - GAP: 4 quarters. `sioc=1`, `siod_oe=0`.
  - NEXT: 1 cycle. If `lut_index==LAST_INDEX`, go to DONE. Otherwise increment `lut_index` and go to LOAD.
  - DONE: lines idle. On `start`: `lut_index←START_INDEX`, clear `nack_seen`, go to LOAD with no power-up wait.
- `start` outside DONE is ignored.

## Timing
- Reset values:
  - state WAIT_PWR
  - `lut_index=START_INDEX`
  - `sioc=1`, `siod_out=1`, `siod_oe=0`
  - `busy=1`, `done=0`, `nack_seen=0`
- First SIOD falling edge: `STARTUP_CYCLES + 1 + QTR` cycles after `rst` deasserts.
- Per entry: `117*QTR + 2` cycles (LOAD + 117 quarters + NEXT).
- Full run: `(LAST_INDEX−START_INDEX+1)` entries, which is 165 with the defaults.
- SIOD only changes while `sioc=0`, except the START falling edge and the STOP rising edge, which occur with `sioc=1`.
- `done` rises 1 cycle after the NEXT cycle on `LAST_INDEX`; `busy` falls on the same cycle.
- `rst` asserted mid-transaction immediately forces the reset values, releasing SIOD with `sioc=1`. The partial write is abandoned and the sequence restarts at WAIT_PWR.
- `lut_index` is stable from NEXT until the following NEXT; `lut_data` is sampled only in LOAD.

## Test plan
Use `CLK_FREQ_HZ=400`, `SCCB_FREQ_HZ=100` (QTR=1), `STARTUP_CYCLES=10`, `START_INDEX=2`, `LAST_INDEX=4` for all scenarios.

- Reset and power-up: release `rst`.
  - Outputs hold reset values for 11 cycles.
  - SIOD falls at cycle 12 with `sioc=1`, and `lut_index=2`.
- Single frame: the LUT returns 16'h3a04 at index 2.
  - An SCCB monitor decodes bytes 0x42, 0x3A, 0x04, with `siod_oe=0` on each 9th bit.
  - The entry lasts 119 cycles, and `lut_index` becomes 3 after NEXT.
- Zero entry: the LUT returns 16'h0000 at index 3.
  - A write 0x42, 0x00, 0x00 is still issued.
- Completion: after index 4, `done=1` and `busy=0`.
  - The total from the first LOAD is exactly 357 cycles; `sioc=1` and `siod_oe=0` hold thereafter.
- NACK then restart: the bench pulls `siod_in=1` during the 2nd don't-care slot of index 3.
  - `nack_seen=1` and stays set through DONE.
  - A `start` pulse in DONE clears it, sets `lut_index=2`, and the first SIOD fall follows 2 cycles later (LOAD + q0).
  - A `start` pulse while busy has no effect.
- Mid-write reset: assert `rst` during SEND bit 15 of index 3.
  - Outputs go to reset values the same cycle.
  - After release, the sequence restarts with WAIT_PWR and `lut_index=2`.
